// File: rtl/dm_resp_unit_if.sv
// Request/response bundle between the DAG/bus-connect side and the
// data-memory responder.
interface dm_resp_unit_if;
  logic        ps_dm_en;
  logic        ps_dm_wrb;
  logic [15:0] dg_dm_add;
  logic [15:0] bc_dt_out;
  logic        dm_ps_rdy;
  logic [15:0] dm_bc_dt;
  logic        dm_bc_vld;
  logic        dm_err;
  logic        dm_idle;

  modport master (
    output ps_dm_en, ps_dm_wrb, dg_dm_add, bc_dt_out,
    input  dm_ps_rdy, dm_bc_dt, dm_bc_vld, dm_err, dm_idle
  );

  modport slave (
    input  ps_dm_en, ps_dm_wrb, dg_dm_add, bc_dt_out,
    output dm_ps_rdy, dm_bc_dt, dm_bc_vld, dm_err, dm_idle
  );
endinterface

// File: rtl/dm_resp_unit.sv
// Data-memory responder: posted-write buffer in front of a single-port
// array, one-cycle read latency with youngest-entry forwarding from the
// buffer. Reads own the array port; writes drain in the cycles reads leave.
module dm_resp_unit #(
  parameter int AW       = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_resp_unit_if.slave bus
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wb_entry_t;

  // Array is deliberately not reset.
  logic [15:0] mem [0:(1<<AW)-1];

  wb_entry_t [WB_DEPTH-1:0] wb_q, wb_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   dm_bc_dt_q, dm_bc_dt_d;
  logic          dm_bc_vld_q, dm_bc_vld_d;
  logic          dm_err_q, dm_err_d;

  logic          full, rdy, acc, in_rng, rd_acc, rd_arr, wr_acc, drain;
  logic          fwd_hit;
  logic [15:0]   fwd_data;
  logic [PW-1:0] fwd_idx;

  // Acceptance, range check and array-port arbitration (reads win).
  always_comb begin
    full   = (count_q == CW'(WB_DEPTH));
    rdy    = ~full;
    acc    = bus.ps_dm_en & rdy;
    in_rng = (bus.dg_dm_add[15:AW] == '0);
    rd_acc = acc & ~bus.ps_dm_wrb;
    rd_arr = rd_acc & in_rng;
    wr_acc = acc & bus.ps_dm_wrb & in_rng;
    drain  = (count_q != '0) & ~rd_arr;
  end

  // Scan oldest to youngest so the last matching valid entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (wb_q[fwd_idx].addr == bus.dg_dm_add[AW-1:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_q[fwd_idx].data;
      end
    end
  end

  // Buffer pointers/contents and registered read response.
  always_comb begin
    wb_d    = wb_q;
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(wr_acc);
    count_d = count_q + CW'(wr_acc) - CW'(drain);
    if (wr_acc) begin
      wb_d[tail_q].addr = bus.dg_dm_add[AW-1:0];
      wb_d[tail_q].data = bus.bc_dt_out;
    end
    dm_bc_vld_d = rd_acc;
    dm_err_d    = acc & ~in_rng;
    dm_bc_dt_d  = dm_bc_dt_q;
    if (rd_acc) begin
      if (!in_rng)     dm_bc_dt_d = '0;
      else if (fwd_hit) dm_bc_dt_d = fwd_data;
      else             dm_bc_dt_d = mem[bus.dg_dm_add[AW-1:0]];
    end
  end

  // State register; reset throws away buffered writes and in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q        <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      dm_bc_dt_q  <= '0;
      dm_bc_vld_q <= 1'b0;
      dm_err_q    <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      dm_bc_dt_q  <= dm_bc_dt_d;
      dm_bc_vld_q <= dm_bc_vld_d;
      dm_err_q    <= dm_err_d;
    end
  end

  // Drain the head entry into the array when the port is free.
  always_ff @(posedge clk) begin
    if (drain) mem[wb_q[head_q].addr] <= wb_q[head_q].data;
  end

  assign bus.dm_ps_rdy = rdy;
  assign bus.dm_bc_dt  = dm_bc_dt_q;
  assign bus.dm_bc_vld = dm_bc_vld_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.dm_idle   = (count_q == '0) & ~rd_acc;
endmodule

// File: tb/tb_dm_resp_unit.sv
// Randomized bench for dm_resp_unit against a queue-based memory model.
module tb_dm_resp_unit;
  localparam int AW = 10;
  localparam int WB_DEPTH = 4;

  logic clk;
  logic rst_n;
  dm_resp_unit_if bus();

  dm_resp_unit #(.AW(AW), .WB_DEPTH(WB_DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } ent_t;

  ent_t        wq[$];
  logic [15:0] mem_m [0:(1<<AW)-1];
  logic [15:0] exp_dt;
  logic        exp_vld, exp_err;
  int          n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] lookup(input logic [15:0] a);
    for (int i = wq.size() - 1; i >= 0; i--)
      if (wq[i].a == a[AW-1:0]) return wq[i].d;
    return mem_m[a[AW-1:0]];
  endfunction

  // One bus cycle; entered and left just after a falling edge.
  task automatic cyc(input logic en, input logic wrb, input logic [15:0] a, input logic [15:0] d);
    logic rdy_e, acc, inr, rd, dr;
    ent_t e;
    bus.ps_dm_en  = en;
    bus.ps_dm_wrb = wrb;
    bus.dg_dm_add = a;
    bus.bc_dt_out = d;
    #1;
    rdy_e = (wq.size() != WB_DEPTH);
    acc   = en & rdy_e;
    inr   = (a >> AW) == 16'd0;
    rd    = acc & ~wrb;
    chk("rdy", 32'(bus.dm_ps_rdy), 32'(rdy_e));
    chk("idle", 32'(bus.dm_idle), 32'(wq.size() == 0 && !rd));
    exp_vld = rd;
    exp_err = acc & ~inr;
    if (rd) exp_dt = inr ? lookup(a) : 16'h0;
    dr = (wq.size() > 0) && !(rd && inr);
    @(posedge clk);
    if (dr) begin
      e = wq.pop_front();
      mem_m[e.a] = e.d;
    end
    if (acc && wrb && inr) begin
      e.a = a[AW-1:0];
      e.d = d;
      wq.push_back(e);
    end
    #1;
    chk("vld", 32'(bus.dm_bc_vld), 32'(exp_vld));
    chk("err", 32'(bus.dm_err), 32'(exp_err));
    chk("dt", 32'(bus.dm_bc_dt), 32'(exp_dt));
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick_addr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4) return 16'h0400;
    if (r < 7) return 16'hFFFF;
    if (r < 10) return 16'h0800 | 16'($urandom_range(0, 16'hF7FF));
    r = $urandom_range(0, 31);
    return (r == 31) ? 16'h03FF : 16'(r);
  endfunction

  initial begin
    n_chk = 0; n_fail = 0;
    exp_dt = '0; exp_vld = 1'b0; exp_err = 1'b0;
    bus.ps_dm_en = 1'b0; bus.ps_dm_wrb = 1'b0;
    bus.dg_dm_add = '0; bus.bc_dt_out = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_dt", 32'(bus.dm_bc_dt), 32'h0);
    chk("rst_vld", 32'(bus.dm_bc_vld), 32'h0);
    chk("rst_err", 32'(bus.dm_err), 32'h0);
    chk("rst_rdy", 32'(bus.dm_ps_rdy), 32'h1);
    chk("rst_idle", 32'(bus.dm_idle), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Give every address the random traffic touches a known value.
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 1'b1, (i == 31) ? 16'h03FF : 16'(i), 16'($urandom));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0);

    // Forwarding of a just-posted write.
    cyc(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0);
    // Youngest duplicate wins.
    cyc(1'b1, 1'b1, 16'h0014, 16'h1111);
    cyc(1'b1, 1'b1, 16'h0014, 16'h2222);
    cyc(1'b1, 1'b0, 16'h0014, 16'h0);
    // Back-to-back writes followed by reads.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 16'(i + 4), 16'hA000 + 16'(i));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'(i + 4), 16'h0);
    // Out-of-range read and write, plus top in-range word.
    cyc(1'b1, 1'b0, 16'h0400, 16'h0);
    cyc(1'b1, 1'b1, 16'hFFFF, 16'h5555);
    cyc(1'b1, 1'b1, 16'h03FF, 16'h7E57);
    cyc(1'b1, 1'b0, 16'h03FF, 16'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pick_addr(), 16'($urandom));

    // Reset with a read response showing and a write still buffered.
    cyc(1'b1, 1'b0, 16'h0003, 16'h0);
    cyc(1'b1, 1'b1, 16'h0005, ~mem_m[5]);
    bus.ps_dm_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    wq.delete();
    exp_dt = '0; exp_vld = 1'b0; exp_err = 1'b0;
    chk("mrst_dt", 32'(bus.dm_bc_dt), 32'h0);
    chk("mrst_vld", 32'(bus.dm_bc_vld), 32'h0);
    chk("mrst_err", 32'(bus.dm_err), 32'h0);
    chk("mrst_rdy", 32'(bus.dm_ps_rdy), 32'h1);
    chk("mrst_idle", 32'(bus.dm_idle), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, 16'h0005, 16'h0);

    // Writes then idle: buffer drains and reads see array data.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'(i + 20), 16'hC000 + 16'(i));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'(i + 20), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
